// File: rtl/mem_arbiter.sv
// Shares one pmem port between IFU and LSU: one request at a time, fixed LAT-cycle access, one-cycle response pulse.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LSU always wins a tie.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        o_dbg_state
);

    // Handshake: a request transfers on the rising edge where valid && ready are both high.
    // Ready is a combinational function of state and the valids, so the requester must hold valid until then.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic              r_grant_lsu;
    logic              r_wen;
    logic              r_hold;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic [DATA_W-1:0] r_lsu_rdata;

    logic              w_tie_lsu;
    logic              w_pick_lsu;
    logic              w_accept;
    logic              w_fire;
    logic              w_last_busy;

`ifdef MEM_ARB_RR_EN
    logic r_last_lsu;

    // Starts at LSU so that the first tie after reset goes to the IFU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_lsu <= 1'b1;
        end else if (w_fire) begin
            r_last_lsu <= w_pick_lsu;
        end
    end

    assign w_tie_lsu = ~r_last_lsu;
`else
    assign w_tie_lsu = 1'b1;
`endif

    // r_hold blocks acceptance for the first cycle after reset so nothing is handshaken while outputs settle to 0.
    assign w_pick_lsu    = lsu_req_valid & (~ifu_req_valid | w_tie_lsu);
    assign w_accept      = (r_state == ST_IDLE) & ~r_hold & ~rst;
    assign lsu_req_ready = w_accept & w_pick_lsu;
    assign ifu_req_ready = w_accept & ifu_req_valid & ~w_pick_lsu;
    assign w_fire        = lsu_req_ready | ifu_req_ready;
    assign w_last_busy   = (r_state == ST_BUSY) & (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // cnt only counts down from CNT_INIT, so equality marks the first BUSY cycle.
                mem_ren = ~r_wen;
                mem_wen = r_wen & (r_cnt == CNT_INIT);
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                ifu_resp_valid = ~r_grant_lsu;
                lsu_resp_valid = r_grant_lsu;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_grant_lsu <= 1'b0;
            r_wen       <= 1'b0;
            r_hold      <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= 8'd0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else begin
            r_hold <= 1'b0;
            if (w_fire) begin
                r_grant_lsu <= w_pick_lsu;
                r_wen       <= w_pick_lsu & lsu_wen;
                r_addr      <= w_pick_lsu ? lsu_addr : ifu_addr;
                r_wdata     <= w_pick_lsu ? lsu_wdata : '0;
                r_wmask     <= w_pick_lsu ? lsu_wmask : 8'd0;
                r_cnt       <= CNT_INIT;
            end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Each requester's data register only changes on its own response, so it holds in between.
            if (w_last_busy) begin
                if (r_grant_lsu) begin
                    r_lsu_rdata <= r_wen ? '0 : mem_rdata;
                end else begin
                    r_ifu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_wmask   = r_wmask;
    assign ifu_rdata   = r_ifu_rdata;
    assign lsu_rdata   = r_lsu_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=2 instance for most scenarios plus a LAT=1 instance for back-to-back reads.
// Expectations follow the round-robin ordering when MEM_ARB_RR_EN is defined for the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = 32'd0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [7:0]  lsu_wmask = 8'd0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic        l1_ifu_req_valid = 1'b0;
    logic        l1_ifu_req_ready;
    logic [31:0] l1_ifu_addr = 32'd0;
    logic        l1_ifu_resp_valid;
    logic [31:0] l1_ifu_rdata;
    logic        l1_lsu_req_valid = 1'b0;
    logic        l1_lsu_req_ready;
    logic        l1_lsu_wen = 1'b0;
    logic [31:0] l1_lsu_addr = 32'd0;
    logic [31:0] l1_lsu_wdata = 32'd0;
    logic [7:0]  l1_lsu_wmask = 8'd0;
    logic        l1_lsu_resp_valid;
    logic [31:0] l1_lsu_rdata;
    logic        l1_mem_ren;
    logic        l1_mem_wen;
    logic [31:0] l1_mem_addr;
    logic [31:0] l1_mem_wdata;
    logic [7:0]  l1_mem_wmask;
    logic [31:0] l1_mem_rdata;
    logic [1:0]  l1_dbg_state;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(l1_ifu_req_valid), .ifu_req_ready(l1_ifu_req_ready), .ifu_addr(l1_ifu_addr),
        .ifu_resp_valid(l1_ifu_resp_valid), .ifu_rdata(l1_ifu_rdata),
        .lsu_req_valid(l1_lsu_req_valid), .lsu_req_ready(l1_lsu_req_ready), .lsu_wen(l1_lsu_wen),
        .lsu_addr(l1_lsu_addr), .lsu_wdata(l1_lsu_wdata), .lsu_wmask(l1_lsu_wmask),
        .lsu_resp_valid(l1_lsu_resp_valid), .lsu_rdata(l1_lsu_rdata),
        .mem_ren(l1_mem_ren), .mem_wen(l1_mem_wen), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_wmask(l1_mem_wmask), .mem_rdata(l1_mem_rdata), .o_dbg_state(l1_dbg_state)
    );

    always #5 clk = ~clk;

    // Memory contents: the boot word at the reset vector, a recognisable pattern elsewhere.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb mem_rdata    = mem_model(mem_addr);
    always_comb l1_mem_rdata = mem_model(l1_mem_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-cycle log written by tick(); cycle numbers are the bench's own cycle count.
    int          fire_cyc[$];
    bit          grant_q[$];
    int          iresp_cyc[$];
    logic [31:0] iresp_dat[$];
    int          lresp_cyc[$];
    logic [31:0] lresp_dat[$];
    int          l1_fire_cyc[$];
    int          l1_resp_cyc[$];
    logic [31:0] l1_resp_dat[$];
    int          ren_cnt, ren_first, ren_last, wen_cnt, wen_cyc, both_rdy;
    logic [31:0] wen_addr, wen_data;
    logic [7:0]  wen_mask;
    logic [1:0]  s_state;
    logic        s_ren, s_wen, s_iresp, s_lresp, s_irdy, s_lrdy;
    bit          keep = 1'b0;
    int          l1_left = 0;

    task automatic clear_log();
        fire_cyc.delete(); grant_q.delete();
        iresp_cyc.delete(); iresp_dat.delete(); lresp_cyc.delete(); lresp_dat.delete();
        l1_fire_cyc.delete(); l1_resp_cyc.delete(); l1_resp_dat.delete();
        ren_cnt = 0; ren_first = -1; ren_last = -1; wen_cnt = 0; wen_cyc = -1; both_rdy = 0;
        wen_addr = 32'd0; wen_data = 32'd0; wen_mask = 8'd0;
    endtask

    // Observe one cycle at the falling edge, then apply requester behaviour just after the rising edge.
    task automatic tick();
        bit f_ifu, f_lsu, f_l1;
        @(negedge clk);
        cyc++;
        s_state = dbg_state; s_ren = mem_ren; s_wen = mem_wen;
        s_iresp = ifu_resp_valid; s_lresp = lsu_resp_valid;
        s_irdy = ifu_req_ready; s_lrdy = lsu_req_ready;
        f_ifu = ifu_req_valid & ifu_req_ready;
        f_lsu = lsu_req_valid & lsu_req_ready;
        f_l1  = l1_ifu_req_valid & l1_ifu_req_ready;
        if (f_ifu) begin fire_cyc.push_back(cyc); grant_q.push_back(1'b0); end
        if (f_lsu) begin fire_cyc.push_back(cyc); grant_q.push_back(1'b1); end
        if (ifu_req_ready && lsu_req_ready) both_rdy++;
        if (ifu_resp_valid) begin iresp_cyc.push_back(cyc); iresp_dat.push_back(ifu_rdata); end
        if (lsu_resp_valid) begin lresp_cyc.push_back(cyc); lresp_dat.push_back(lsu_rdata); end
        if (mem_ren) begin ren_cnt++; if (ren_first < 0) ren_first = cyc; ren_last = cyc; end
        if (mem_wen) begin wen_cnt++; wen_cyc = cyc; wen_addr = mem_addr; wen_data = mem_wdata; wen_mask = mem_wmask; end
        if (f_l1) l1_fire_cyc.push_back(cyc);
        if (l1_ifu_resp_valid) begin l1_resp_cyc.push_back(cyc); l1_resp_dat.push_back(l1_ifu_rdata); end
        @(posedge clk);
        #1;
        if (f_ifu) begin if (keep) ifu_addr = ifu_addr + 32'd4; else ifu_req_valid = 1'b0; end
        if (f_lsu) begin if (keep) lsu_addr = lsu_addr + 32'd4; else lsu_req_valid = 1'b0; end
        if (f_l1) begin
            if (l1_left > 0) begin l1_left--; l1_ifu_addr = l1_ifu_addr + 32'd4; end
            else l1_ifu_req_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; keep = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; l1_ifu_req_valid = 1'b0; lsu_wen = 1'b0;
        tick(); tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        clear_log();
        rst = 1'b1; ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_0010;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        tick(); tick();
        n_tests++; if (s_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", s_state); end
        n_tests++; if ({s_ren, s_wen, s_iresp, s_lresp} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b expected 0000", {s_ren, s_wen, s_iresp, s_lresp}); end
        n_tests++; if ({s_irdy, s_lrdy} !== 2'b00) begin n_fail++; $display("FAIL rst_ready_in_rst: got %b expected 00", {s_irdy, s_lrdy}); end
        n_tests++; if (ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_regs: got ifu_rdata %h lsu_rdata %h mem_addr %h expected 0", ifu_rdata, lsu_rdata, mem_addr); end
        rst = 1'b0;
        tick();
        n_tests++; if ({s_irdy, s_lrdy} !== 2'b00) begin n_fail++; $display("FAIL rst_ready_after: got %b expected 00", {s_irdy, s_lrdy}); end
        for (int i = 0; i < 14; i++) tick();
    endtask

    task automatic test_ifu_read();
        int t;
        do_reset();
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_tests++; if (fire_cyc.size() != 1) begin n_fail++; $display("FAIL t1_fire_count: got %0d expected 1", fire_cyc.size()); end
        t = fire_cyc[0];
        n_tests++; if (ren_first != t + 1 || ren_last != t + 2 || ren_cnt != 2) begin n_fail++; $display("FAIL t1_ren_window: got %0d..%0d (%0d) expected %0d..%0d (2)", ren_first, ren_last, ren_cnt, t + 1, t + 2); end
        n_tests++; if (iresp_cyc.size() != 1 || iresp_cyc[0] != t + 3) begin n_fail++; $display("FAIL t1_resp_cyc: got %0d (n=%0d) expected %0d", iresp_cyc[0], iresp_cyc.size(), t + 3); end
        n_tests++; if (iresp_dat[0] !== 32'h0010_0073) begin n_fail++; $display("FAIL t1_rdata: got %h expected 00100073", iresp_dat[0]); end
        n_tests++; if (lresp_cyc.size() != 0 || wen_cnt != 0) begin n_fail++; $display("FAIL t1_no_lsu: got lsu_resp %0d wen %0d expected 0 0", lresp_cyc.size(), wen_cnt); end
        n_tests++; if (ifu_rdata !== 32'h0010_0073) begin n_fail++; $display("FAIL t1_rdata_hold: got %h expected 00100073", ifu_rdata); end
    endtask

    task automatic test_tie();
        int  t, exp_l, exp_i;
        bit  exp_first;
`ifdef MEM_ARB_RR_EN
        exp_first = 1'b0;
`else
        exp_first = 1'b1;
`endif
        do_reset();
        ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        t = fire_cyc[0];
        exp_l = exp_first ? t + 3 : t + 7;
        exp_i = exp_first ? t + 7 : t + 3;
        n_tests++; if (grant_q.size() != 2 || grant_q[0] != exp_first || grant_q[1] == exp_first) begin n_fail++; $display("FAIL t2_order: got n=%0d first=%0d expected first=%0d", grant_q.size(), grant_q[0], exp_first); end
        n_tests++; if (fire_cyc[1] != t + 4) begin n_fail++; $display("FAIL t2_second_fire: got %0d expected %0d", fire_cyc[1], t + 4); end
        n_tests++; if (lresp_cyc.size() != 1 || lresp_cyc[0] != exp_l) begin n_fail++; $display("FAIL t2_lsu_resp: got %0d expected %0d", lresp_cyc[0], exp_l); end
        n_tests++; if (iresp_cyc.size() != 1 || iresp_cyc[0] != exp_i) begin n_fail++; $display("FAIL t2_ifu_resp: got %0d expected %0d", iresp_cyc[0], exp_i); end
        n_tests++; if (lresp_dat[0] !== 32'h0010_FFEF || iresp_dat[0] !== 32'h0010_0073) begin n_fail++; $display("FAIL t2_data: got lsu %h ifu %h expected 0010ffef 00100073", lresp_dat[0], iresp_dat[0]); end
        n_tests++; if (both_rdy != 0) begin n_fail++; $display("FAIL t2_one_ready: got %0d cycles with both ready expected 0", both_rdy); end
    endtask

    task automatic test_write();
        int t;
        do_reset();
        lsu_addr = 32'h8000_0020; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_tests++; if (lresp_dat.size() != 1 || lresp_dat[0] !== 32'h0020_FFDF) begin n_fail++; $display("FAIL t3_pre_read: got %h expected 0020ffdf", lresp_dat[0]); end
        clear_log();
        lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_wen = 1'b1; lsu_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        lsu_wen = 1'b0;
        t = fire_cyc[0];
        n_tests++; if (wen_cnt != 1 || wen_cyc != t + 1) begin n_fail++; $display("FAIL t3_wen_pulse: got %0d pulses at %0d expected 1 at %0d", wen_cnt, wen_cyc, t + 1); end
        n_tests++; if (ren_cnt != 0) begin n_fail++; $display("FAIL t3_no_ren: got %0d expected 0", ren_cnt); end
        n_tests++; if (wen_addr !== 32'h8000_1000 || wen_data !== 32'hDEAD_BEEF || wen_mask !== 8'h0F) begin n_fail++; $display("FAIL t3_wr_fields: got %h %h %h expected 80001000 deadbeef 0f", wen_addr, wen_data, wen_mask); end
        n_tests++; if (lresp_cyc.size() != 1 || lresp_cyc[0] != t + 3) begin n_fail++; $display("FAIL t3_ack_cyc: got %0d expected %0d", lresp_cyc[0], t + 3); end
        n_tests++; if (lresp_dat[0] !== 32'd0) begin n_fail++; $display("FAIL t3_ack_data: got %h expected 0", lresp_dat[0]); end
        n_tests++; if (iresp_cyc.size() != 0 || ifu_rdata !== 32'd0) begin n_fail++; $display("FAIL t3_ifu_quiet: got n=%0d ifu_rdata %h expected 0 0", iresp_cyc.size(), ifu_rdata); end
    endtask

    task automatic test_rr();
        bit exp_g[4];
        int exp_ni;
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1}; exp_ni = 3;
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1}; exp_ni = 1;
`endif
        do_reset();
        ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; keep = 1'b1;
        for (int i = 0; i < 40 && grant_q.size() < 4; i++) tick();
        keep = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_tests++; if (grant_q.size() != 6) begin n_fail++; $display("FAIL t4_total: got %0d fires expected 6", grant_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (grant_q[i] != exp_g[i]) begin n_fail++; $display("FAIL t4_grant%0d: got %0d expected %0d (1=LSU)", i, grant_q[i], exp_g[i]); end
        end
        n_tests++; if (fire_cyc[3] != fire_cyc[0] + 12) begin n_fail++; $display("FAIL t4_spacing: got %0d expected %0d", fire_cyc[3], fire_cyc[0] + 12); end
        n_tests++; if (iresp_cyc.size() != exp_ni || lresp_cyc.size() != 6 - exp_ni) begin n_fail++; $display("FAIL t4_resp_split: got ifu %0d lsu %0d expected %0d %0d", iresp_cyc.size(), lresp_cyc.size(), exp_ni, 6 - exp_ni); end
    endtask

    task automatic test_reset_midflight();
        int t;
        do_reset();
        ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1;
        for (int i = 0; i < 10 && fire_cyc.size() < 1; i++) tick();
        t = fire_cyc[0];
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ifu_addr = 32'h8000_0044; ifu_req_valid = 1'b1;
        tick();
        n_tests++; if (s_state !== 2'd0) begin n_fail++; $display("FAIL t5_state: got %0d expected 0", s_state); end
        n_tests++; if ({s_ren, s_wen, s_iresp, s_lresp, s_irdy, s_lrdy} !== 6'b0) begin n_fail++; $display("FAIL t5_outputs: got %b expected 000000", {s_ren, s_wen, s_iresp, s_lresp, s_irdy, s_lrdy}); end
        n_tests++; if (ifu_rdata !== 32'd0) begin n_fail++; $display("FAIL t5_discard: got %h expected 0", ifu_rdata); end
        for (int i = 0; i < 10; i++) tick();
        n_tests++; if (fire_cyc.size() != 2 || fire_cyc[1] != t + 4) begin n_fail++; $display("FAIL t5_refire: got %0d expected %0d", fire_cyc[1], t + 4); end
        n_tests++; if (iresp_cyc.size() != 1 || iresp_cyc[0] != t + 7 || iresp_dat[0] !== 32'h0044_FFBB) begin n_fail++; $display("FAIL t5_new_resp: got n=%0d at %0d data %h expected 1 at %0d data 0044ffbb", iresp_cyc.size(), iresp_cyc[0], iresp_dat[0], t + 7); end

        do_reset();
        lsu_addr = 32'h8000_2000; lsu_wdata = 32'h1234_5678; lsu_wmask = 8'hFF; lsu_wen = 1'b1; lsu_req_valid = 1'b1;
        for (int i = 0; i < 10 && fire_cyc.size() < 1; i++) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; lsu_wen = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_tests++; if (wen_cnt != 1 || lresp_cyc.size() != 0) begin n_fail++; $display("FAIL t5_write_once: got wen %0d acks %0d expected 1 0", wen_cnt, lresp_cyc.size()); end
    endtask

    task automatic test_back_to_back_lat1();
        int t;
        do_reset();
        l1_ifu_addr = 32'h8000_0000; l1_left = 1; l1_ifu_req_valid = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        t = l1_fire_cyc[0];
        n_tests++; if (l1_fire_cyc.size() != 2 || l1_fire_cyc[1] != t + 3) begin n_fail++; $display("FAIL t6_fires: got n=%0d second %0d expected 2 second %0d", l1_fire_cyc.size(), l1_fire_cyc[1], t + 3); end
        n_tests++; if (l1_resp_cyc.size() != 2 || l1_resp_cyc[0] != t + 2 || l1_resp_cyc[1] != t + 5) begin n_fail++; $display("FAIL t6_resp_cyc: got %0d %0d expected %0d %0d", l1_resp_cyc[0], l1_resp_cyc[1], t + 2, t + 5); end
        n_tests++; if (l1_resp_dat[0] !== 32'h0010_0073 || l1_resp_dat[1] !== 32'h0004_FFFB) begin n_fail++; $display("FAIL t6_data: got %h %h expected 00100073 0004fffb", l1_resp_dat[0], l1_resp_dat[1]); end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_tie();
        test_write();
        test_rr();
        test_reset_midflight();
        test_back_to_back_lat1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
